// File: rtl/mem_wb_stage_p.sv
// MEM/WB pipeline register and writeback-source select for the register-file write
// port, with sub-word load extension, misalignment flag and a saturating retire counter.
module mem_wb_stage_p #(
  parameter int DATA_W   = 32,
  parameter int RADDR_W  = 5,
  parameter int CNT_W    = 32,
  parameter int ZERO_REG = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic               in_reg_write,
  input  logic [1:0]         in_wb_src,
  input  logic [2:0]         in_load_type,
  input  logic [1:0]         in_byte_off,
  input  logic [DATA_W-1:0]  in_alu_res,
  input  logic [DATA_W-1:0]  in_read_data,
  input  logic [DATA_W-1:0]  in_link_pc,
  input  logic [RADDR_W-1:0] in_rd,
  output logic               wb_valid,
  output logic               wb_en,
  output logic [RADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0]  wb_data,
  output logic               wb_misalign,
  output logic [CNT_W-1:0]   retire_count
);

  localparam logic [2:0] LT_LB  = 3'd1;
  localparam logic [2:0] LT_LBU = 3'd2;
  localparam logic [2:0] LT_LH  = 3'd3;
  localparam logic [2:0] LT_LHU = 3'd4;

  logic               vld_p1;
  logic               reg_write_p1;
  logic [1:0]         wb_src_p1;
  logic [2:0]         load_type_p1;
  logic [1:0]         byte_off_p1;
  logic [DATA_W-1:0]  alu_res_p1;
  logic [DATA_W-1:0]  read_data_p1;
  logic [DATA_W-1:0]  link_pc_p1;
  logic [RADDR_W-1:0] rd_p1;
  logic [CNT_W-1:0]   count;
  logic               capture;

  // Sub-word extraction; halves ignore byte_off[0], words ignore the offset entirely.
  function automatic logic signed [DATA_W-1:0] extend_load(
    input logic [2:0]        lt,
    input logic [1:0]        off,
    input logic [DATA_W-1:0] word
  );
    logic [7:0]                lane;
    logic [15:0]               half;
    logic signed [DATA_W-1:0]  ext;
    lane = word[{off, 3'b000} +: 8];
    half = off[1] ? word[31:16] : word[15:0];
    case (lt)
      LT_LB:   ext = {{(DATA_W-8){lane[7]}}, lane};
      LT_LBU:  ext = {{(DATA_W-8){1'b0}}, lane};
      LT_LH:   ext = {{(DATA_W-16){half[15]}}, half};
      LT_LHU:  ext = {{(DATA_W-16){1'b0}}, half};
      default: ext = word;
    endcase
    return ext;
  endfunction

  assign capture = in_valid & ~stall & ~flush;

  // Stage boundary MEM -> WB: bubbles clear valid but leave the payload as it was.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1       <= 1'b0;
      reg_write_p1 <= 1'b0;
      wb_src_p1    <= '0;
      load_type_p1 <= '0;
      byte_off_p1  <= '0;
      alu_res_p1   <= '0;
      read_data_p1 <= '0;
      link_pc_p1   <= '0;
      rd_p1        <= '0;
    end else begin
      vld_p1 <= capture;
      if (capture) begin
        reg_write_p1 <= in_reg_write;
        wb_src_p1    <= in_wb_src;
        load_type_p1 <= in_load_type;
        byte_off_p1  <= in_byte_off;
        alu_res_p1   <= in_alu_res;
        read_data_p1 <= in_read_data;
        link_pc_p1   <= in_link_pc;
        rd_p1        <= in_rd;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (vld_p1 && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

  always_comb begin
    wb_data = alu_res_p1;
    case (wb_src_p1)
      2'd1:    wb_data = extend_load(load_type_p1, byte_off_p1, read_data_p1);
      2'd2:    wb_data = link_pc_p1;
      default: wb_data = alu_res_p1;
    endcase
  end

  always_comb begin
    logic is_half;
    logic is_word;
    is_half     = (load_type_p1 == LT_LH) || (load_type_p1 == LT_LHU);
    is_word     = !(is_half || (load_type_p1 == LT_LB) || (load_type_p1 == LT_LBU));
    wb_misalign = vld_p1 && (wb_src_p1 == 2'd1) &&
                  ((is_half && byte_off_p1[0]) || (is_word && (byte_off_p1 != 2'd0)));
  end

  assign wb_valid     = vld_p1;
  assign wb_addr      = rd_p1;
  assign wb_en        = vld_p1 & reg_write_p1 & ~((ZERO_REG != 0) && (rd_p1 == '0));
  assign retire_count = count;

endmodule

// File: tb/tb_mem_wb_stage_p.sv
// Bench for mem_wb_stage_p: directed vector table, reset/stall/flush/saturation
// sequences, then randomized traffic against a behavioural model.
module tb_mem_wb_stage_p;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, in_valid, in_reg_write;
  logic [1:0]  in_wb_src;
  logic [2:0]  in_load_type;
  logic [1:0]  in_byte_off;
  logic [31:0] in_alu_res, in_read_data, in_link_pc;
  logic [4:0]  in_rd;

  logic        wb_valid, wb_en, wb_misalign;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] retire_count;

  logic        s_valid, s_en, s_misalign;
  logic [4:0]  s_addr;
  logic [31:0] s_data;
  logic [2:0]  s_count;

  always #5 clk = ~clk;

  mem_wb_stage_p #(.DATA_W(32), .RADDR_W(5), .CNT_W(32), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_reg_write(in_reg_write), .in_wb_src(in_wb_src), .in_load_type(in_load_type),
    .in_byte_off(in_byte_off), .in_alu_res(in_alu_res), .in_read_data(in_read_data),
    .in_link_pc(in_link_pc), .in_rd(in_rd), .wb_valid(wb_valid), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .wb_misalign(wb_misalign),
    .retire_count(retire_count)
  );

  mem_wb_stage_p #(.DATA_W(32), .RADDR_W(5), .CNT_W(3), .ZERO_REG(1)) dut_small (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_reg_write(in_reg_write), .in_wb_src(in_wb_src), .in_load_type(in_load_type),
    .in_byte_off(in_byte_off), .in_alu_res(in_alu_res), .in_read_data(in_read_data),
    .in_link_pc(in_link_pc), .in_rd(in_rd), .wb_valid(s_valid), .wb_en(s_en),
    .wb_addr(s_addr), .wb_data(s_data), .wb_misalign(s_misalign),
    .retire_count(s_count)
  );

  int passed = 0;
  int total  = 0;

  // Model of what sits in WB: the last accepted instruction plus whether it is live.
  logic        m_valid, m_rw;
  logic [1:0]  m_src;
  logic [2:0]  m_lt;
  logic [1:0]  m_off;
  logic [31:0] m_alu, m_rdata, m_link;
  logic [4:0]  m_rd;
  longint      m_cnt;
  int          m_cnt_s;

  typedef struct {
    logic [1:0]  src;
    logic [2:0]  lt;
    logic [1:0]  off;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] link;
    logic [31:0] exp_data;
    logic        exp_mis;
    logic        exp_en;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] ref_data(input logic [1:0] src, input logic [2:0] lt,
                                           input logic [1:0] off, input logic [31:0] alu,
                                           input logic [31:0] rdata, input logic [31:0] link);
    longint unsigned b, h;
    if (src == 2) return link;
    if (src != 1) return alu;
    b = (longint'(rdata) >> (8 * int'(off))) % 256;
    h = (off >= 2) ? (longint'(rdata) / 65536) : (longint'(rdata) % 65536);
    case (lt)
      3'd1: return (b >= 128) ? 32'(b + 64'hFFFF_FF00) : 32'(b);
      3'd2: return 32'(b);
      3'd3: return (h >= 32768) ? 32'(h + 64'hFFFF_0000) : 32'(h);
      3'd4: return 32'(h);
      default: return rdata;
    endcase
  endfunction

  function automatic logic ref_mis(input logic v, input logic [1:0] src,
                                   input logic [2:0] lt, input logic [1:0] off);
    if (!v || src != 1) return 1'b0;
    if (lt == 3 || lt == 4) return (off % 2) == 1;
    if (lt == 1 || lt == 2) return 1'b0;
    return off != 0;
  endfunction

  task automatic model_clear();
    m_valid = 0; m_rw = 0; m_src = 0; m_lt = 0; m_off = 0;
    m_alu = 0; m_rdata = 0; m_link = 0; m_rd = 0; m_cnt = 0; m_cnt_s = 0;
  endtask

  task automatic step();
    @(posedge clk);
    if (m_valid) begin
      if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
      if (m_cnt_s < 7) m_cnt_s++;
    end
    if (in_valid && !stall && !flush) begin
      m_valid = 1; m_rw = in_reg_write; m_src = in_wb_src; m_lt = in_load_type;
      m_off = in_byte_off; m_alu = in_alu_res; m_rdata = in_read_data;
      m_link = in_link_pc; m_rd = in_rd;
    end else begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, " wb_valid"}, 32'(wb_valid), 32'(m_valid));
    chk({tag, " wb_en"}, 32'(wb_en), 32'(m_valid && m_rw && m_rd != 0));
    chk({tag, " wb_misalign"}, 32'(wb_misalign), 32'(ref_mis(m_valid, m_src, m_lt, m_off)));
    chk({tag, " retire_count"}, retire_count, 32'(m_cnt));
    chk({tag, " small retire_count"}, 32'(s_count), 32'(m_cnt_s));
    if (m_valid) begin
      chk({tag, " wb_addr"}, 32'(wb_addr), 32'(m_rd));
      chk({tag, " wb_data"}, wb_data, ref_data(m_src, m_lt, m_off, m_alu, m_rdata, m_link));
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic [1:0] src,
                       input logic [2:0] lt, input logic [1:0] off, input logic [31:0] alu,
                       input logic [31:0] rdata, input logic [31:0] link, input logic [4:0] rd);
    in_valid = v; in_reg_write = rw; in_wb_src = src; in_load_type = lt;
    in_byte_off = off; in_alu_res = alu; in_read_data = rdata; in_link_pc = link; in_rd = rd;
  endtask

  initial begin
    tbl[0]  = '{2'd0, 3'd0, 2'd0, 1'b1, 5'd7,  32'h0000_1234, 32'h0, 32'h0, 32'h0000_1234, 1'b0, 1'b1};
    tbl[1]  = '{2'd1, 3'd1, 2'd3, 1'b1, 5'd5,  32'hDEAD_BEEF, 32'h80FF_7F01, 32'h0, 32'hFFFF_FF80, 1'b0, 1'b1};
    tbl[2]  = '{2'd1, 3'd2, 2'd3, 1'b1, 5'd6,  32'hDEAD_BEEF, 32'h80FF_7F01, 32'h0, 32'h0000_0080, 1'b0, 1'b1};
    tbl[3]  = '{2'd1, 3'd1, 2'd1, 1'b1, 5'd8,  32'hDEAD_BEEF, 32'h80FF_7F01, 32'h0, 32'h0000_007F, 1'b0, 1'b1};
    tbl[4]  = '{2'd1, 3'd3, 2'd2, 1'b1, 5'd9,  32'hDEAD_BEEF, 32'h80FF_7F01, 32'h0, 32'hFFFF_80FF, 1'b0, 1'b1};
    tbl[5]  = '{2'd1, 3'd4, 2'd0, 1'b1, 5'd10, 32'hDEAD_BEEF, 32'h80FF_7F01, 32'h0, 32'h0000_7F01, 1'b0, 1'b1};
    tbl[6]  = '{2'd1, 3'd0, 2'd0, 1'b1, 5'd11, 32'hDEAD_BEEF, 32'h80FF_7F01, 32'h0, 32'h80FF_7F01, 1'b0, 1'b1};
    tbl[7]  = '{2'd1, 3'd3, 2'd1, 1'b1, 5'd12, 32'hDEAD_BEEF, 32'h80FF_7F01, 32'h0, 32'h0000_7F01, 1'b1, 1'b1};
    tbl[8]  = '{2'd1, 3'd0, 2'd2, 1'b1, 5'd13, 32'hDEAD_BEEF, 32'h80FF_7F01, 32'h0, 32'h80FF_7F01, 1'b1, 1'b1};
    tbl[9]  = '{2'd2, 3'd0, 2'd0, 1'b1, 5'd31, 32'hDEAD_BEEF, 32'h0, 32'h0040_0008, 32'h0040_0008, 1'b0, 1'b1};
    tbl[10] = '{2'd0, 3'd0, 2'd0, 1'b1, 5'd0,  32'h0000_0055, 32'h0, 32'h0, 32'h0000_0055, 1'b0, 1'b0};
    tbl[11] = '{2'd3, 3'd6, 2'd1, 1'b1, 5'd3,  32'h0000_A5A5, 32'h0, 32'h0, 32'h0000_A5A5, 1'b0, 1'b1};

    rst_n = 0; stall = 0; flush = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_clear();
    #12;
    chk("reset wb_valid", 32'(wb_valid), 32'h0);
    chk("reset wb_en", 32'(wb_en), 32'h0);
    chk("reset wb_addr", 32'(wb_addr), 32'h0);
    chk("reset wb_data", wb_data, 32'h0);
    chk("reset wb_misalign", 32'(wb_misalign), 32'h0);
    chk("reset retire_count", retire_count, 32'h0);
    rst_n = 1;

    for (int i = 0; i < 12; i++) begin
      drive(1, tbl[i].rw, tbl[i].src, tbl[i].lt, tbl[i].off, tbl[i].alu, tbl[i].rdata,
            tbl[i].link, tbl[i].rd);
      step();
      chk($sformatf("vec%0d wb_valid", i), 32'(wb_valid), 32'h1);
      chk($sformatf("vec%0d wb_data", i), wb_data, tbl[i].exp_data);
      chk($sformatf("vec%0d wb_misalign", i), 32'(wb_misalign), 32'(tbl[i].exp_mis));
      chk($sformatf("vec%0d wb_en", i), 32'(wb_en), 32'(tbl[i].exp_en));
      chk($sformatf("vec%0d wb_addr", i), 32'(wb_addr), 32'(tbl[i].rd));
      chk($sformatf("vec%0d retire_count", i), retire_count, 32'(m_cnt));
    end

    // Stall, flush, then both, each with a valid instruction offered.
    drive(1, 1, 0, 0, 0, 32'h1111_2222, 0, 0, 5'd4);
    stall = 1; flush = 0; step(); check_all("stall");
    stall = 0; flush = 1; step(); check_all("flush");
    stall = 1; flush = 1; step(); check_all("stall+flush");
    chk("bubble retire_count held", retire_count, 32'd12);
    stall = 0; flush = 0; drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(); check_all("idle");

    // Reset mid-stream: an LW in WB is discarded and never written.
    drive(1, 1, 1, 0, 0, 0, 32'h1234_5678, 0, 5'd9);
    step(); check_all("pre-reset lw");
    rst_n = 0; #2;
    chk("midreset wb_valid", 32'(wb_valid), 32'h0);
    chk("midreset wb_en", 32'(wb_en), 32'h0);
    chk("midreset wb_data", wb_data, 32'h0);
    chk("midreset retire_count", retire_count, 32'h0);
    chk("midreset small count", 32'(s_count), 32'h0);
    model_clear();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1;
    step(); check_all("post-reset");
    chk("post-reset no write", 32'(wb_en), 32'h0);

    // Nine back-to-back instructions saturate the 3-bit counter at 7.
    for (int i = 0; i < 9; i++) begin
      drive(1, i[0], 0, 0, 0, 32'(i), 0, 0, 5'(i + 1));
      step(); check_all("sat");
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();
    chk("saturated small count", 32'(s_count), 32'd7);
    chk("wide count after nine", retire_count, 32'd9);

    for (int i = 0; i < 400; i++) begin
      stall = ($urandom % 8) == 0;
      flush = ($urandom % 8) == 0;
      drive(($urandom % 4) != 0, $urandom % 2, 2'($urandom % 4), 3'($urandom % 8),
            2'($urandom % 4), $urandom, $urandom, $urandom,
            (($urandom % 6) == 0) ? 5'd0 : 5'($urandom % 32));
      step(); check_all("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage_p.md
Name: mem_wb_stage_p

Overview:
- Parametrised MEM/WB pipeline register plus writeback-select stage; the successor to the fixed 32-bit ALU/memory writeback path.
- Registers memory-stage results, then selects one of three writeback sources: ALU result, sign/zero-extended load data, or link PC.
- Drives the register-file write port and a forwarding tap for the execute-stage bypass.
- Adds stall/flush bubble insertion, sub-word loads, a misalignment flag, and a retired-instruction counter.

Parameters:
DATA_W, 32, datapath width; only 32 is supported (byte/half extraction assumes 4 byte lanes).
RADDR_W, 5, register address width.
CNT_W, 32, retire counter width.
ZERO_REG, 1, when 1, writes to register 0 are suppressed.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
stall  in  1  MEM stage holding; WB captures a bubble.
flush  in  1  squash incoming instruction; WB captures a bubble.
in_valid  in  1  incoming instruction valid.
in_reg_write  in  1  instruction writes the register file.
in_wb_src  in  2  0 = ALU, 1 = memory, 2 = link, 3 = ALU.
in_load_type  in  3  0 = LW, 1 = LB, 2 = LBU, 3 = LH, 4 = LHU; 5..7 behave as LW.
in_byte_off  in  2  load address bits [1:0].
in_alu_res  in  DATA_W  ALU result.
in_read_data  in  DATA_W  raw memory word.
in_link_pc  in  DATA_W  return address (PC+8).
in_rd  in  RADDR_W  destination register.
wb_valid  out  1  registered valid.
wb_en  out  1  register-file write enable.
wb_addr  out  RADDR_W  register-file write address.
wb_data  out  DATA_W  register-file write data.
wb_misalign  out  1  misaligned load present in WB.
retire_count  out  CNT_W  instructions retired.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - All stage registers clear: wb_valid = 0, wb_en = 0, wb_addr = 0, wb_data = 0, wb_misalign = 0.
  - retire_count = 0.
  - Reset taken mid-operation discards the in-flight instruction; no write occurs.
- Capture on each rising clk:
  - If flush OR stall OR !in_valid: valid <= 0 (bubble). Other fields are don't-care, but the implementation holds them unchanged.
  - Otherwise, all in_* fields are latched and valid <= 1.
  - flush and stall together: bubble.
- Latency: an instruction presented at edge N drives wb_* after edge N. Each instruction occupies WB for exactly one cycle, so it is never written twice.
- Outputs are combinational from the stage registers only, with no in_* to out path:
  - wb_addr = registered rd.
  - wb_en = valid & reg_write & !(ZERO_REG & rd == 0).
  - wb_valid = valid.
- wb_data by registered source:
  - src 0/3: alu_res.
  - src 2: link_pc.
  - src 1: extended load data, where byte lane k = read_data[8k+7:8k], k = byte_off (little-endian):
    - LB sign-extends lane k; LBU zero-extends lane k.
    - LH/LHU take read_data[31:16] when byte_off[1] = 1, else [15:0]; LH sign-extends, LHU zero-extends.
    - LW passes the word through.
- wb_misalign = valid & src == 1 & one of:
  - (LH or LHU) with byte_off[0] = 1;
  - LW with byte_off != 0.
  - Data is still produced as above (byte_off[0] ignored for halves; LW ignores the offset).
  - wb_en is not gated by misalignment; the trap unit owns that decision.
- retire_count: on each edge where valid = 1, increments by 1. Bubbles do not count; instructions with reg_write = 0 do count. Saturates at all-ones and does not wrap.

Test Plan:
- Reset mid-stream: valid LW in flight, pulse rst_n low between edges -> all outputs 0 immediately, retire_count 0, no wb_en pulse after release.
- ALU write: in_valid = 1, in_reg_write = 1, src 0, rd = 7, alu = 0x0000_1234 -> next cycle wb_en = 1, wb_addr = 7, wb_data = 0x0000_1234, retire_count 0 -> 1.
- Loads on read_data = 0x80FF_7F01:
  - LB off = 3 -> 0xFFFF_FF80.
  - LBU off = 3 -> 0x0000_0080.
  - LB off = 1 -> 0x0000_007F.
  - LH off = 2 -> 0xFFFF_80FF.
  - LHU off = 0 -> 0x0000_7F01.
  - LW -> 0x80FF_7F01.
  - wb_misalign = 0 for all of the above.
- Misalign: LH off = 1 -> wb_misalign = 1, wb_data = 0x0000_7F01 sign-extended (0x0000_7F01); LW off = 2 -> wb_misalign = 1.
- Stall/flush: valid instruction with stall = 1, then flush = 1, then both -> wb_valid = 0 and wb_en = 0 each cycle, retire_count unchanged. rd = 0 with reg_write = 1 -> wb_en = 0 but retire_count increments.
- Link and saturation: src 2, link_pc = 0x0040_0008, rd = 31 -> wb_data = 0x0040_0008. With CNT_W = 3, 9 valid instructions -> retire_count stops at 7.
